// File: rtl/dp_mem_arbiter_pkg.sv
// Shared types and helpers for the dual-port memory arbiter.
// Defaults match the 32 x 8 banked memory.
package dp_mem_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;
    localparam int BL_DEF = 4;
    localparam int RL_DEF = 1;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_e;

    // Low bits wrap inside the bank; the bank bit never changes.
    function automatic logic [AW_DEF-1:0] bank_wrap_addr(
        input logic [AW_DEF-1:0] start,
        input logic [AW_DEF-2:0] k
    );
        logic [AW_DEF-2:0] low;
        low = start[AW_DEF-2:0] + k;
        return {start[AW_DEF-1], low};
    endfunction

endpackage

// File: rtl/dp_mem_arbiter_if.sv
// Client request/response bundle.
// The master is the client; the slave is the arbiter.
interface dp_mem_arbiter_if #(
    parameter int AW = dp_mem_pkg::AW_DEF,
    parameter int DW = dp_mem_pkg::DW_DEF
);
    logic          req;
    logic          we;
    logic          burst;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          wnext;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          done;

    modport master (
        output req, we, burst, addr, wdata,
        input  gnt, wnext, rvalid, rdata, done
    );

    modport slave (
        input  req, we, burst, addr, wdata,
        output gnt, wnext, rvalid, rdata, done
    );
endinterface

// File: rtl/dp_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// The pointer moves past the winner only when a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = req_i;
        prio_d = prio_q;
        if (req_i == 2'b11) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
        if (accept_i && |req_i) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/dp_mem_arbiter.sv
// Two-client arbiter and burst sequencer for the banked memory.
// One transaction at a time; reads return through a latency pipe.
module dp_mem_arbiter
    import dp_mem_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_LEN = BL_DEF,
    parameter int RD_LAT    = RL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    dp_mem_arbiter_if.slave       c0,
    dp_mem_arbiter_if.slave       c1,
    output logic                  mem_enb,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic                  mem_burst,
    output logic [AW-1:0]         mem_w_addr,
    output logic [AW-1:0]         mem_r_addr,
    output logic [DW-1:0]         mem_w_data,
    input  logic [DW-1:0]         mem_r_data
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LW = AW - 1;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic            burst_q, burst_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            wdone_q, wdone_d;
    logic [AW-1:0]   waddr_q, raddr_q;

    logic [RD_LAT-1:0] pv_q, pl_q, pc_q;

    logic [1:0]      req;
    logic [1:0]      arb_gnt;
    logic            accept;
    logic            wr_beat, rd_beat, last_beat;
    logic [AW-1:0]   beat_addr;
    logic [DW-1:0]   sel_wdata;
    logic            out_v, out_l, out_c;
    logic            busy, r0, r1;

    assign req    = {c1.req, c0.req};
    assign accept = (state_q == IDLE) && |req;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .accept_i (accept),
        .gnt_o    (arb_gnt)
    );

    assign beat_addr = bank_wrap_addr(addr_q, LW'(beat_q));
    assign sel_wdata = owner_q ? c1.wdata : c0.wdata;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        burst_d   = burst_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        wdone_d   = 1'b0;
        wr_beat   = 1'b0;
        rd_beat   = 1'b0;
        last_beat = burst_q ? (beat_q == BW'(BURST_LEN - 1)) : 1'b1;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = XFER;
                    owner_d = arb_gnt[1];
                    we_d    = arb_gnt[1] ? c1.we    : c0.we;
                    burst_d = arb_gnt[1] ? c1.burst : c0.burst;
                    addr_d  = arb_gnt[1] ? c1.addr  : c0.addr;
                    beat_d  = '0;
                end
            end
            XFER: begin
                wr_beat = we_q;
                rd_beat = !we_q;
                if (last_beat) begin
                    beat_d  = '0;
                    state_d = we_q ? IDLE : DRAIN;
                    wdone_d = we_q;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_v && out_l) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot 0 is loaded in the mem_rd cycle, so the top slot lines up with data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
            wdone_q <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            wdone_q <= wdone_d;
            waddr_q <= mem_w_addr;
            raddr_q <= mem_r_addr;
            pv_q[0] <= rd_beat;
            pl_q[0] <= rd_beat & last_beat;
            pc_q[0] <= owner_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
        end
    end

    assign out_v = pv_q[RD_LAT-1];
    assign out_l = pl_q[RD_LAT-1];
    assign out_c = pc_q[RD_LAT-1];
    assign busy  = (state_q != IDLE);
    assign r0    = out_v & !out_c;
    assign r1    = out_v & out_c;

    assign mem_enb    = (state_q == XFER);
    assign mem_wr     = wr_beat;
    assign mem_rd     = rd_beat;
    assign mem_burst  = busy & burst_q;
    assign mem_w_addr = wr_beat ? beat_addr : waddr_q;
    assign mem_r_addr = rd_beat ? beat_addr : raddr_q;
    assign mem_w_data = wr_beat ? sel_wdata : '0;

    assign c0.gnt    = busy & !owner_q;
    assign c0.wnext  = wr_beat & !owner_q;
    assign c0.rvalid = r0;
    assign c0.rdata  = r0 ? mem_r_data : '0;
    assign c0.done   = (wdone_q & !owner_q) | (r0 & out_l);

    assign c1.gnt    = busy & owner_q;
    assign c1.wnext  = wr_beat & owner_q;
    assign c1.rvalid = r1;
    assign c1.rdata  = r1 ? mem_r_data : '0;
    assign c1.done   = (wdone_q & owner_q) | (r1 & out_l);
endmodule
